// File: rtl/cci_test_mmio_pkg.sv
// Shared types and constants for the CCI-P MMIO test initiator.
package cci_test_mmio_pkg;

    localparam int unsigned MMIO_SLOT_IDX_W = 4;

    typedef logic [MMIO_SLOT_IDX_W-1:0] t_mmio_slot_idx;
    typedef logic [15:0]                t_cci_mmio_addr;
    typedef logic [8:0]                 t_ccip_tid;

    typedef struct packed {
        logic           is_write;
        t_cci_mmio_addr addr;
        logic [63:0]    data;
    } t_mmio_cmd;

    localparam logic [1:0] MMIO_LEN_8B = 2'b01;

endpackage

// File: rtl/cci_test_mmio_tid_tracker.sv
// Read-slot tracker: busy bitmap, per-slot timeout timers and the
// lowest-free / lowest-expired priority encoders.
module cci_test_mmio_tid_tracker
    import cci_test_mmio_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alloc_en,
    output t_mmio_slot_idx             alloc_idx,
    output logic                       any_free,
    input  logic                       rsp_free_en,
    input  t_mmio_slot_idx             rsp_free_idx,
    input  logic                       exp_ack,
    output logic                       exp_valid,
    output t_mmio_slot_idx             exp_idx,
    output logic [MAX_OUTSTANDING-1:0] busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer [MAX_OUTSTANDING];

    // A slot being freed by a response this cycle never counts as expired.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        exp_valid = 1'b0;
        exp_idx   = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!busy[i] && !any_free) begin
                any_free  = 1'b1;
                alloc_idx = t_mmio_slot_idx'(i);
            end
            if (busy[i] && (timer[i] == '0) && !exp_valid &&
                !(rsp_free_en && (rsp_free_idx == t_mmio_slot_idx'(i)))) begin
                exp_valid = 1'b1;
                exp_idx   = t_mmio_slot_idx'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (alloc_en && any_free && (alloc_idx == t_mmio_slot_idx'(i))) begin
                    busy[i]  <= 1'b1;
                    timer[i] <= TIMER_LOAD;
                end else if ((rsp_free_en && (rsp_free_idx == t_mmio_slot_idx'(i))) ||
                             (exp_ack && exp_valid && (exp_idx == t_mmio_slot_idx'(i)))) begin
                    busy[i] <= 1'b0;
                end else if (busy[i] && (timer[i] != '0)) begin
                    timer[i] <= timer[i] - TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cci_test_mmio_initiator.sv
// Host-side MMIO initiator: issues c0Rx-style CSR requests, matches c2Tx read
// responses by TID, and reports timeout / bad-TID / misaligned errors.
module cci_test_mmio_initiator
    import cci_test_mmio_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_write,
    input  logic [15:0]          cmd_addr,
    input  logic [63:0]          cmd_data,
    output logic                 mmio_rd_valid,
    output logic                 mmio_wr_valid,
    output logic [15:0]          mmio_addr,
    output logic [8:0]           mmio_tid,
    output logic [1:0]           mmio_len,
    output logic [63:0]          mmio_data,
    input  logic                 rsp_valid,
    input  logic [8:0]           rsp_tid,
    input  logic [63:0]          rsp_data,
    output logic                 rd_done_valid,
    output logic [8:0]           rd_done_tid,
    output logic [63:0]          rd_done_data,
    output logic                 err_misaligned,
    output logic                 err_timeout,
    output logic                 err_bad_tid,
    output logic [8:0]           err_tid,
    output logic [4:0]           num_outstanding,
    output logic [CNT_WIDTH-1:0] rd_issued_cnt
);

    logic [1:0]                 rst_sync;
    t_mmio_cmd                  cmd;
    logic                       accept, rd_issue, wr_issue, mis_now;
    logic                       rsp_hit, rsp_bad, mis_pend, mis_fire, exp_fire;
    logic [MAX_OUTSTANDING-1:0] busy;
    t_mmio_slot_idx             alloc_idx, exp_idx;
    logic                       any_free, exp_valid;
    logic [4:0]                 busy_cnt;

    cci_test_mmio_tid_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_tracker (
        .clk          (clk),
        .reset_n      (reset_n),
        .alloc_en     (rd_issue),
        .alloc_idx    (alloc_idx),
        .any_free     (any_free),
        .rsp_free_en  (rsp_valid && rsp_hit),
        .rsp_free_idx (t_mmio_slot_idx'(rsp_tid)),
        .exp_ack      (exp_fire),
        .exp_valid    (exp_valid),
        .exp_idx      (exp_idx),
        .busy         (busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    always_comb begin
        cmd       = '{is_write: cmd_is_write, addr: cmd_addr, data: cmd_data};
        cmd_ready = rst_sync[1] && !(cmd_valid && !cmd.is_write && !any_free);
        accept    = cmd_valid && cmd_ready;
        mis_now   = accept && cmd.addr[0];
        rd_issue  = accept && !cmd.is_write && !cmd.addr[0];
        wr_issue  = accept &&  cmd.is_write && !cmd.addr[0];
        rsp_hit   = 1'b0;
        busy_cnt  = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (busy[i] && (rsp_tid == t_ccip_tid'(i))) rsp_hit = 1'b1;
            busy_cnt = busy_cnt + 5'(busy[i]);
        end
        rsp_bad  = rsp_valid && !rsp_hit;
        // Expiry waits (timer held at 0) while a bad TID owns the error pulse.
        exp_fire = exp_valid && !rsp_bad;
        mis_fire = (mis_now || mis_pend) && !rsp_bad && !exp_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmio_rd_valid   <= 1'b0;
            mmio_wr_valid   <= 1'b0;
            mmio_addr       <= '0;
            mmio_tid        <= '0;
            mmio_len        <= '0;
            mmio_data       <= '0;
            rd_done_valid   <= 1'b0;
            rd_done_tid     <= '0;
            rd_done_data    <= '0;
            err_misaligned  <= 1'b0;
            err_timeout     <= 1'b0;
            err_bad_tid     <= 1'b0;
            err_tid         <= '0;
            mis_pend        <= 1'b0;
            num_outstanding <= '0;
            rd_issued_cnt   <= '0;
        end else begin
            mmio_rd_valid <= rd_issue;
            mmio_wr_valid <= wr_issue;
            if (rd_issue || wr_issue) begin
                mmio_addr <= cmd.addr;
                mmio_tid  <= rd_issue ? t_ccip_tid'(alloc_idx) : '0;
                mmio_len  <= MMIO_LEN_8B;
                mmio_data <= rd_issue ? '0 : cmd.data;
            end
            rd_done_valid <= rsp_valid && rsp_hit;
            if (rsp_valid && rsp_hit) begin
                rd_done_tid  <= rsp_tid;
                rd_done_data <= rsp_data;
            end
            err_bad_tid    <= rsp_bad;
            err_timeout    <= exp_fire;
            err_misaligned <= mis_fire;
            if (rsp_bad)       err_tid <= rsp_tid;
            else if (exp_fire) err_tid <= t_ccip_tid'(exp_idx);
            else               err_tid <= '0;
            mis_pend        <= (mis_now || mis_pend) && !mis_fire;
            num_outstanding <= busy_cnt;
            if (rd_issue && (rd_issued_cnt != '1))
                rd_issued_cnt <= rd_issued_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cci_test_mmio_initiator.sv
// Directed self-checking bench for cci_test_mmio_initiator.
module tb_cci_test_mmio_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_is_write;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_data;
    logic        mmio_rd_valid, mmio_wr_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [1:0]  mmio_len;
    logic [63:0] mmio_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        rd_done_valid;
    logic [8:0]  rd_done_tid;
    logic [63:0] rd_done_data;
    logic        err_misaligned, err_timeout, err_bad_tid;
    logic [8:0]  err_tid;
    logic [4:0]  num_outstanding;
    logic [15:0] rd_issued_cnt;

    int checks = 0;
    int failures = 0;

    cci_test_mmio_initiator #(
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (16),
        .CNT_WIDTH       (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_write    (cmd_is_write),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .mmio_rd_valid   (mmio_rd_valid),
        .mmio_wr_valid   (mmio_wr_valid),
        .mmio_addr       (mmio_addr),
        .mmio_tid        (mmio_tid),
        .mmio_len        (mmio_len),
        .mmio_data       (mmio_data),
        .rsp_valid       (rsp_valid),
        .rsp_tid         (rsp_tid),
        .rsp_data        (rsp_data),
        .rd_done_valid   (rd_done_valid),
        .rd_done_tid     (rd_done_tid),
        .rd_done_data    (rd_done_data),
        .err_misaligned  (err_misaligned),
        .err_timeout     (err_timeout),
        .err_bad_tid     (err_bad_tid),
        .err_tid         (err_tid),
        .num_outstanding (num_outstanding),
        .rd_issued_cnt   (rd_issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [63:0] d);
        cmd_valid = 1'b1; cmd_is_write = w; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [8:0] t, input logic [63:0] d);
        rsp_valid = 1'b1; rsp_tid = t; rsp_data = d;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; cmd_valid = 1'b0; cmd_is_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%0h exp=0", cmd_ready); end
        checks++; if ({mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_len, mmio_data} !== '0) begin failures++; $display("FAIL reset_mmio got_addr=%0h got_len=%0h exp=0", mmio_addr, mmio_len); end
        checks++; if ({rd_done_valid, err_misaligned, err_timeout, err_bad_tid, err_tid, num_outstanding, rd_issued_cnt} !== '0) begin failures++; $display("FAIL reset_status got_num=%0d got_cnt=%0d exp=0", num_outstanding, rd_issued_cnt); end
        reset_n = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL sync_1cycle_ready got=%0h exp=0", cmd_ready); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL sync_2cycle_ready got=%0h exp=1", cmd_ready); end
    endtask

    task automatic test_write();
        send_cmd(1'b1, 16'h0040, 64'h0000_0000_DEAD_BEEF);
        checks++; if (mmio_wr_valid !== 1'b1 || mmio_rd_valid !== 1'b0) begin failures++; $display("FAIL wr_pulse got_wr=%0h got_rd=%0h exp=1/0", mmio_wr_valid, mmio_rd_valid); end
        checks++; if (mmio_addr !== 16'h0040) begin failures++; $display("FAIL wr_addr got=%0h exp=40", mmio_addr); end
        checks++; if (mmio_tid !== 9'd0 || mmio_len !== 2'b01) begin failures++; $display("FAIL wr_tid_len got_tid=%0d got_len=%0d exp=0/1", mmio_tid, mmio_len); end
        checks++; if (mmio_data !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("FAIL wr_data got=%0h exp=deadbeef", mmio_data); end
        tick();
        checks++; if (mmio_wr_valid !== 1'b0) begin failures++; $display("FAIL wr_single_pulse got=%0h exp=0", mmio_wr_valid); end
    endtask

    task automatic test_reads_out_of_order();
        int order [4] = '{3, 1, 0, 2};
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b0, 16'(2 * i), 64'hFFFF_FFFF_FFFF_FFFF);
            checks++; if (mmio_rd_valid !== 1'b1 || mmio_tid !== 9'(i) || mmio_addr !== 16'(2 * i) || mmio_data !== 64'd0) begin failures++; $display("FAIL rd_issue_%0d got_v=%0h tid=%0d addr=%0h data=%0h exp=1/%0d/%0h/0", i, mmio_rd_valid, mmio_tid, mmio_addr, mmio_data, i, 2 * i); end
        end
        cmd_valid = 1'b1; cmd_is_write = 1'b0; cmd_addr = 16'h0008;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_rd_ready got=%0h exp=0", cmd_ready); end
        cmd_is_write = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_wr_ready got=%0h exp=1", cmd_ready); end
        cmd_valid = 1'b0;
        tick();
        checks++; if (num_outstanding !== 5'd4) begin failures++; $display("FAIL num_out_full got=%0d exp=4", num_outstanding); end
        for (int k = 0; k < 4; k++) begin
            send_rsp(9'(order[k]), 64'hC0DE_0000_0000_0000 + 64'(order[k]));
            checks++; if (rd_done_valid !== 1'b1 || rd_done_tid !== 9'(order[k]) || rd_done_data !== 64'hC0DE_0000_0000_0000 + 64'(order[k])) begin failures++; $display("FAIL rd_done_%0d got_v=%0h tid=%0d data=%0h exp_tid=%0d", k, rd_done_valid, rd_done_tid, rd_done_data, order[k]); end
            if (k == 0) begin
                cmd_valid = 1'b1; cmd_is_write = 1'b0;
                #1;
                checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_rsp got=%0h exp=1", cmd_ready); end
                cmd_valid = 1'b0;
            end
        end
        tick();
        checks++; if (num_outstanding !== 5'd0 || rd_done_valid !== 1'b0) begin failures++; $display("FAIL drained got_num=%0d got_done=%0h exp=0/0", num_outstanding, rd_done_valid); end
        checks++; if (rd_issued_cnt !== 16'd4) begin failures++; $display("FAIL cnt_after_4 got=%0d exp=4", rd_issued_cnt); end
    endtask

    task automatic test_timeout();
        int early = 0;
        send_cmd(1'b0, 16'h0010, '0);
        checks++; if (mmio_rd_valid !== 1'b1 || mmio_tid !== 9'd0) begin failures++; $display("FAIL to_issue got_v=%0h tid=%0d exp=1/0", mmio_rd_valid, mmio_tid); end
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (err_timeout !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin failures++; $display("FAIL to_early got=%0d exp=0", early); end
        checks++; if (num_outstanding !== 5'd1) begin failures++; $display("FAIL to_num_busy got=%0d exp=1", num_outstanding); end
        tick();
        checks++; if (err_timeout !== 1'b1 || err_tid !== 9'd0) begin failures++; $display("FAIL to_pulse got_v=%0h tid=%0d exp=1/0", err_timeout, err_tid); end
        tick();
        checks++; if (err_timeout !== 1'b0 || num_outstanding !== 5'd0) begin failures++; $display("FAIL to_after got_v=%0h num=%0d exp=0/0", err_timeout, num_outstanding); end
        send_rsp(9'd0, 64'h1234);
        checks++; if (err_bad_tid !== 1'b1 || err_tid !== 9'd0 || rd_done_valid !== 1'b0) begin failures++; $display("FAIL late_rsp got_bad=%0h tid=%0d done=%0h exp=1/0/0", err_bad_tid, err_tid, rd_done_valid); end
        checks++; if (rd_issued_cnt !== 16'd5) begin failures++; $display("FAIL cnt_after_to got=%0d exp=5", rd_issued_cnt); end
    endtask

    task automatic test_rsp_vs_expiry();
        int spurious = 0;
        send_cmd(1'b0, 16'h0020, '0);
        send_cmd(1'b0, 16'h0022, '0);
        send_rsp(9'd0, 64'hAAAA);
        checks++; if (rd_done_valid !== 1'b1 || rd_done_tid !== 9'd0) begin failures++; $display("FAIL col_slot0 got_v=%0h tid=%0d exp=1/0", rd_done_valid, rd_done_tid); end
        repeat (14) begin
            tick();
            if (err_timeout !== 1'b0) spurious++;
        end
        send_rsp(9'd1, 64'hBBBB);
        checks++; if (rd_done_valid !== 1'b1 || rd_done_tid !== 9'd1 || rd_done_data !== 64'hBBBB) begin failures++; $display("FAIL col_done got_v=%0h tid=%0d data=%0h exp=1/1/bbbb", rd_done_valid, rd_done_tid, rd_done_data); end
        if (err_timeout !== 1'b0) spurious++;
        tick();
        if (err_timeout !== 1'b0) spurious++;
        checks++; if (spurious !== 0) begin failures++; $display("FAIL col_no_timeout got=%0d exp=0", spurious); end
        tick();
        checks++; if (num_outstanding !== 5'd0 || rd_issued_cnt !== 16'd7) begin failures++; $display("FAIL col_end got_num=%0d cnt=%0d exp=0/7", num_outstanding, rd_issued_cnt); end
    endtask

    task automatic test_misaligned_bad_tid();
        send_cmd(1'b0, 16'h0003, '0);
        checks++; if (err_misaligned !== 1'b1 || err_tid !== 9'd0) begin failures++; $display("FAIL mis_pulse got_v=%0h tid=%0d exp=1/0", err_misaligned, err_tid); end
        checks++; if (mmio_rd_valid !== 1'b0 || mmio_wr_valid !== 1'b0) begin failures++; $display("FAIL mis_no_req got_rd=%0h wr=%0h exp=0/0", mmio_rd_valid, mmio_wr_valid); end
        tick();
        checks++; if (num_outstanding !== 5'd0 || rd_issued_cnt !== 16'd7 || err_misaligned !== 1'b0) begin failures++; $display("FAIL mis_state got_num=%0d cnt=%0d mis=%0h exp=0/7/0", num_outstanding, rd_issued_cnt, err_misaligned); end
        send_rsp(9'd9, 64'h99);
        checks++; if (err_bad_tid !== 1'b1 || err_tid !== 9'd9 || rd_done_valid !== 1'b0) begin failures++; $display("FAIL bad_tid9 got_v=%0h tid=%0d done=%0h exp=1/9/0", err_bad_tid, err_tid, rd_done_valid); end
        // Misaligned write and a bad response in the same cycle.
        cmd_valid = 1'b1; cmd_is_write = 1'b1; cmd_addr = 16'h0005; cmd_data = 64'h55;
        rsp_valid = 1'b1; rsp_tid = 9'd7; rsp_data = '0;
        tick();
        cmd_valid = 1'b0; rsp_valid = 1'b0;
        checks++; if (err_bad_tid !== 1'b1 || err_tid !== 9'd7 || err_misaligned !== 1'b0) begin failures++; $display("FAIL prio_bad got_bad=%0h tid=%0d mis=%0h exp=1/7/0", err_bad_tid, err_tid, err_misaligned); end
        tick();
        checks++; if (err_misaligned !== 1'b1 || err_tid !== 9'd0 || err_bad_tid !== 1'b0) begin failures++; $display("FAIL prio_mis_queued got_mis=%0h tid=%0d bad=%0h exp=1/0/0", err_misaligned, err_tid, err_bad_tid); end
    endtask

    task automatic test_reset_mid_op();
        send_cmd(1'b0, 16'h0100, '0);
        send_cmd(1'b0, 16'h0102, '0);
        send_cmd(1'b0, 16'h0104, '0);
        checks++; if (mmio_rd_valid !== 1'b1 || mmio_tid !== 9'd2) begin failures++; $display("FAIL mid_issue got_v=%0h tid=%0d exp=1/2", mmio_rd_valid, mmio_tid); end
        reset_n = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b0 || mmio_rd_valid !== 1'b0 || mmio_tid !== 9'd0 || mmio_addr !== 16'd0) begin failures++; $display("FAIL mid_reset_out got_rdy=%0h rd=%0h tid=%0d addr=%0h exp=0", cmd_ready, mmio_rd_valid, mmio_tid, mmio_addr); end
        checks++; if (num_outstanding !== 5'd0 || rd_issued_cnt !== 16'd0 || err_timeout !== 1'b0) begin failures++; $display("FAIL mid_reset_stat got_num=%0d cnt=%0d to=%0h exp=0", num_outstanding, rd_issued_cnt, err_timeout); end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_back got=%0h exp=1", cmd_ready); end
        send_cmd(1'b0, 16'h0200, '0);
        checks++; if (mmio_rd_valid !== 1'b1 || mmio_tid !== 9'd0 || rd_issued_cnt !== 16'd1) begin failures++; $display("FAIL mid_new_tid got_v=%0h tid=%0d cnt=%0d exp=1/0/1", mmio_rd_valid, mmio_tid, rd_issued_cnt); end
        send_rsp(9'd1, 64'h77);
        checks++; if (err_bad_tid !== 1'b1 || err_tid !== 9'd1) begin failures++; $display("FAIL mid_lost_slot got_bad=%0h tid=%0d exp=1/1", err_bad_tid, err_tid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_reads_out_of_order();
        test_timeout();
        test_rsp_vs_expiry();
        test_misaligned_bad_tid();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
